// File: rtl/obi_bridge_pkg.sv
// Shared types for the mem-to-OBI bridge: FIFO entry layouts and defaults.
// Tags are carried at TAG_MAX width internally; the top truncates to TAG_WIDTH.
package obi_bridge_pkg;

  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int TAG_MAX = 32;

  typedef logic [TAG_MAX-1:0] tag_t;

  typedef struct packed {
    logic rw;
    tag_t tag;
  } tag_ent_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] data;
  } rsp_ent_t;

endpackage

// File: rtl/obi_req_if.sv
// OBI request phase: master drives req/we/be/addr/wdata, slave returns gnt.
// Ports: req, we, be[3:0], addr[31:0], wdata[31:0] (master out); gnt (in).
interface obi_req_if;

  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt
  );

endinterface

// File: rtl/bridge_fifo.sv
// Show-ahead FIFO with flop storage; push while full is accepted with a pop.
// Ports: clk, reset, i_push, i_wdata, i_pop, o_rdata, o_full, o_empty.
module bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  // when full, the slot being written is the one being popped
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/mem_obi_bridge.sv
// Bridges a valid/ready mem request/response port onto OBI, credit-limited.
// Ports: clk, reset, mem_req_*, mem_rsp_*, obi_req (master), obi_rvalid/rdata, protocol_err.
module mem_obi_bridge
  import obi_bridge_pkg::*;
#(
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  output logic                 mem_req_ready,
  input  logic                 mem_req_rw,
  input  logic [3:0]           mem_req_byteen,
  input  logic [31:0]          mem_req_addr,
  input  logic [31:0]          mem_req_data,
  input  logic [TAG_WIDTH-1:0] mem_req_tag,
  output logic                 mem_rsp_valid,
  input  logic                 mem_rsp_ready,
  output logic [31:0]          mem_rsp_data,
  output logic [TAG_WIDTH-1:0] mem_rsp_tag,
  obi_req_if.master            obi_req,
  input  logic                 obi_rvalid,
  input  logic [31:0]          obi_rdata,
  output logic                 protocol_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [CW-1:0] r_credit_cnt;
  logic          r_perr;

  logic     w_credit_ok;
  logic     w_xfer;
  logic     w_tag_empty;
  logic     w_tag_full;
  logic     w_rv_ok;
  logic     w_wr_rsp;
  logic     w_rd_rsp;
  logic     w_rsp_pop;
  logic     w_rsp_empty;
  logic     w_rsp_full;
  tag_ent_t w_tag_in;
  tag_ent_t w_tag_out;
  rsp_ent_t w_rsp_in;
  rsp_ent_t w_rsp_out;
  logic [CW-1:0] w_credit_nxt;

  assign w_credit_ok = (r_credit_cnt < CW'(MAX_OUTSTANDING));

  // reset gating keeps req low even though the cleared count reads as credit
  assign obi_req.req   = mem_req_valid & w_credit_ok & ~reset;
  assign obi_req.we    = mem_req_rw;
  assign obi_req.be    = mem_req_byteen;
  assign obi_req.addr  = mem_req_addr;
  assign obi_req.wdata = mem_req_data;

  assign mem_req_ready = obi_req.gnt & w_credit_ok & ~reset;
  assign w_xfer        = mem_req_valid & mem_req_ready;

  assign w_tag_in.rw  = mem_req_rw;
  assign w_tag_in.tag = tag_t'(mem_req_tag);

  // an rvalid against an empty tag FIFO has nothing to match and is dropped
  assign w_rv_ok  = obi_rvalid & ~w_tag_empty;
  assign w_wr_rsp = w_rv_ok & w_tag_out.rw;
  assign w_rd_rsp = w_rv_ok & ~w_tag_out.rw;

  assign w_rsp_in.tag  = w_tag_out.tag;
  assign w_rsp_in.data = obi_rdata;

  assign mem_rsp_valid = ~w_rsp_empty & ~reset;
  assign w_rsp_pop     = mem_rsp_valid & mem_rsp_ready;
  assign mem_rsp_data  = w_rsp_out.data;
  assign mem_rsp_tag   = TAG_WIDTH'(w_rsp_out.tag);
  assign protocol_err  = r_perr;

  generate
    if (TAG_WIDTH < TAG_MAX) begin : g_tag_pad
      logic w_tag_unused;
      assign w_tag_unused = ^w_rsp_out.tag[TAG_MAX-1:TAG_WIDTH];
    end
  endgenerate

  // a write response and a read pop can retire two credits in one cycle
  assign w_credit_nxt = r_credit_cnt
                      + CW'(w_xfer)
                      - CW'(w_wr_rsp)
                      - CW'(w_rsp_pop);

  bridge_fifo #(
    .WIDTH ($bits(tag_ent_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_xfer),
    .i_wdata (w_tag_in),
    .i_pop   (obi_rvalid),
    .o_rdata (w_tag_out),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  bridge_fifo #(
    .WIDTH ($bits(rsp_ent_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rd_rsp),
    .i_wdata (w_rsp_in),
    .i_pop   (w_rsp_pop),
    .o_rdata (w_rsp_out),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

  logic w_full_unused;
  assign w_full_unused = w_tag_full ^ w_rsp_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit_cnt <= '0;
      r_perr       <= 1'b0;
    end else begin
      r_credit_cnt <= w_credit_nxt;
      if (obi_rvalid & w_tag_empty) r_perr <= 1'b1;
    end
  end

endmodule
